enemy_spawner: RTL
==================

// Module: enemy_spawner
// PURPOSE
//  Upstream sequencer for the Enemy car. Picks a pseudo-random lane and drives offset_x/offset_y.
//  Pulses Enemy's enable to respawn the car at the top, then watches Enemy's pos_y for exit.
//  Counts cars passed as the score and freezes on collision. Runs in the game logic clock
//  domain, the same clock as Enemy's logic_clk.
// PARAMETERS
//  NUM_LANES   4        lanes available, legal range 1..4
//  LANE_X0     160      offset_x of lane 0 (px)
//  LANE_PITCH  80       x distance between lanes (px)
//  START_Y     0        offset_y driven to Enemy
//  EXIT_Y      600      pos_y at or above which the car counts as passed (Enemy stops at 600)
//  SPAWN_GAP   60       clk cycles spent in GAP before the next spawn, must be >=1
//  LFSR_SEED   16'hACE1 LFSR reset value, must be nonzero
// PORTS
//  clk          in   1   game logic clock (feeds Enemy logic_clk)
//  reset        in   1   synchronous, active-high
//  run          in   1   game running; 0 forces IDLE
//  collision    in   1   player/enemy collision flag
//  enemy_pos_y  in   10  Enemy pos_y
//  offset_x     out  10  lane x to Enemy offset_x; registered
//  offset_y     out  10  to Enemy offset_y; registered, always START_Y
//  enable       out  1   one-cycle respawn pulse to Enemy enable; registered
//  lane         out  2   current lane index
//  crashed      out  1   1 while in HALT
//  score        out  8   cars passed, saturates at 255
// BEHAVIOUR
//  Reset values
//   - state=IDLE, lfsr=LFSR_SEED, lane=0, offset_x=LANE_X0, offset_y=START_Y
//   - enable=0, crashed=0, score=0, gap_cnt=0
//  LFSR
//   - 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Steps every non-reset cycle in all states.
//   - A zero value reloads LFSR_SEED.
//  Lane pick, in PICK
//   - r = lfsr[1:0]; if r >= NUM_LANES then r = r - NUM_LANES.
//   - If r == lane and NUM_LANES > 1, then r = (lane + 1) mod NUM_LANES.
//   - lane <= r; offset_x <= LANE_X0 + r*LANE_PITCH, 10-bit, no overflow for legal parameters.
//  States
//   - IDLE:   enable=0. run=1 -> PICK.
//   - PICK:   update lane/offset_x -> LOAD.
//   - LOAD:   enable=1 for exactly this cycle; offset_x already stable -> ACTIVE.
//   - ACTIVE: first cycle masks exit compare (Enemy pos_y clears at the LOAD edge).
//             collision=1 -> HALT, checked before exit.
//             enemy_pos_y >= EXIT_Y -> GAP; score += 1 unless already 255; gap_cnt <= SPAWN_GAP-1.
//   - GAP:    gap_cnt decrements; at 0 -> PICK.
//   - HALT:   crashed=1; offset_x, lane and score held; enable=0. Left only by reset.
//  Timing and event rules
//   - Latency: run rises at edge N -> PICK at N+1, enable=1 during N+2, ACTIVE at N+3.
//   - collision is ignored outside ACTIVE.
//   - run=0 in any state except HALT -> IDLE next cycle, enable=0; score and lane held.
//   - reset wins over run, collision and exit.
//   - Reset mid-operation restores all reset values on the next edge, including inside HALT.
//   - offset_x changes only in PICK, so the car never shifts lane while visible.
// TESTING
//  - reset, run=1 at cyc 0 -> enable high only in cyc 2; offset_x in {160,240,320,400}.
//  - ACTIVE, drive enemy_pos_y 599 then 600 -> GAP entered on 600.
//      score 0->1; enable next asserted exactly SPAWN_GAP+2 cycles later.
//  - 200 consecutive spawns -> lane never equals previous lane; all 4 lanes appear; score=200.
//  - ACTIVE with collision=1 and pos_y=600 same cycle -> HALT, crashed=1, score unchanged.
//      Then 100 idle cycles -> no enable, offset_x stable.
//  - Force score to 255, then one more exit -> score stays 255.
//  - reset asserted in GAP and again in HALT -> all outputs at reset values next edge.
//      run held 1 -> enable again 2 cycles after reset drops.

Source files
------------

// File: rtl/enemy_spawner_if.sv
// Signal bundle between the enemy spawner sequencer and its game-side environment.
// The slave side is the spawner; the master side supplies run/collision/pos_y.
interface enemy_spawner_if;
    logic       run;
    logic       collision;
    logic [9:0] enemy_pos_y;
    logic [9:0] offset_x;
    logic [9:0] offset_y;
    logic       enable;
    logic [1:0] lane;
    logic       crashed;
    logic [7:0] score;

    modport master (
        output run, collision, enemy_pos_y,
        input  offset_x, offset_y, enable, lane, crashed, score
    );

    modport slave (
        input  run, collision, enemy_pos_y,
        output offset_x, offset_y, enable, lane, crashed, score
    );
endinterface

// File: rtl/enemy_spawner.sv
// Enemy car sequencer: picks a pseudo-random lane, pulses a respawn, watches for the car
// leaving the screen, keeps score and freezes on collision.
module enemy_spawner #(
    parameter int          NUM_LANES  = 4,
    parameter int          LANE_X0    = 160,
    parameter int          LANE_PITCH = 80,
    parameter int          START_Y    = 0,
    parameter int          EXIT_Y     = 600,
    parameter int          SPAWN_GAP  = 60,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input logic             clk,
    input logic             reset,
    enemy_spawner_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, PICK, LOAD, ACTIVE, GAP, HALT} state_t;

    localparam int          GW       = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(SPAWN_GAP - 1);
    localparam logic [9:0]  X0       = 10'(LANE_X0);
    localparam logic [9:0]  PITCH    = 10'(LANE_PITCH);
    localparam logic [9:0]  Y0       = 10'(START_Y);
    localparam logic [9:0]  EXIT     = 10'(EXIT_Y);
    localparam logic [2:0]  NL       = 3'(NUM_LANES);
    localparam logic [15:0] TAPS     = 16'hB400;

    state_t        state, state_nxt;
    logic [15:0]   lfsr, lfsr_nxt, lfsr_step;
    logic [1:0]    lane_q, lane_nxt, pick_lane;
    logic [9:0]    offset_x_q, offset_x_nxt, offset_y_q, pick_x;
    logic          enable_q, enable_nxt;
    logic          crashed_q, crashed_nxt;
    logic [7:0]    score_q, score_nxt;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic          first_active, first_nxt;
    logic [2:0]    r3, l3;

    // Galois LFSR, right-shifting; a stuck-at-zero register recovers to the seed
    always_comb begin
        lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
        lfsr_nxt  = (lfsr == 16'h0000) ? LFSR_SEED : lfsr_step;
    end

    always_comb begin
        r3 = {1'b0, lfsr[1:0]};
        if (r3 >= NL) r3 = r3 - NL;
        if (NUM_LANES == 1) r3 = 3'd0;
        l3 = {1'b0, lane_q} + 3'd1;
        if (l3 >= NL) l3 = 3'd0;
        // never respawn in the lane the previous car used
        if (NUM_LANES > 1 && r3[1:0] == lane_q) r3 = l3;
        pick_lane = r3[1:0];
        pick_x    = X0 + PITCH * {8'd0, pick_lane};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            lfsr         <= LFSR_SEED;
            lane_q       <= 2'd0;
            offset_x_q   <= X0;
            offset_y_q   <= Y0;
            enable_q     <= 1'b0;
            crashed_q    <= 1'b0;
            score_q      <= 8'd0;
            gap_cnt      <= '0;
            first_active <= 1'b0;
        end else begin
            state        <= state_nxt;
            lfsr         <= lfsr_nxt;
            lane_q       <= lane_nxt;
            offset_x_q   <= offset_x_nxt;
            offset_y_q   <= Y0;
            enable_q     <= enable_nxt;
            crashed_q    <= crashed_nxt;
            score_q      <= score_nxt;
            gap_cnt      <= gap_nxt;
            first_active <= first_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        lane_nxt     = lane_q;
        offset_x_nxt = offset_x_q;
        score_nxt    = score_q;
        gap_nxt      = gap_cnt;
        first_nxt    = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.run) state_nxt = PICK;
            end
            PICK: begin
                lane_nxt     = pick_lane;
                offset_x_nxt = pick_x;
                state_nxt    = LOAD;
            end
            LOAD: begin
                state_nxt = ACTIVE;
                first_nxt = 1'b1;
            end
            ACTIVE: begin
                // Enemy pos_y is still stale on the first ACTIVE cycle
                if (bus.collision) begin
                    state_nxt = HALT;
                end else if (!first_active && bus.enemy_pos_y >= EXIT) begin
                    state_nxt = GAP;
                    score_nxt = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    gap_nxt   = GAP_LOAD;
                end
            end
            GAP: begin
                if (gap_cnt == '0) state_nxt = PICK;
                else               gap_nxt   = gap_cnt - 1'b1;
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: state_nxt = IDLE;
        endcase

        if (state != HALT && !bus.run) begin
            state_nxt    = IDLE;
            lane_nxt     = lane_q;
            offset_x_nxt = offset_x_q;
            score_nxt    = score_q;
            first_nxt    = 1'b0;
        end

        enable_nxt  = (state_nxt == LOAD);
        crashed_nxt = (state_nxt == HALT);
    end

    assign bus.offset_x = offset_x_q;
    assign bus.offset_y = offset_y_q;
    assign bus.enable   = enable_q;
    assign bus.lane     = lane_q;
    assign bus.crashed  = crashed_q;
    assign bus.score    = score_q;

endmodule
